// File: rtl/clock_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : clock_prescaler
// Brief   : Free-running binary divider, clk_out = clk / 2**N, 50% duty.
//           Optional one-cycle wrap strobe 'tick' under CLOCK_PRESCALER_TICK_EN.
// Revision: 1.0  initial release
// ============================================================================
module clock_prescaler #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic         clk_out,
  output logic [N-1:0] count
`ifdef CLOCK_PRESCALER_TICK_EN
  ,
  output logic         tick
`endif
);

  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [N-1:0] CNT_MAX = '1;

  logic [N-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Output is the counter MSB straight from the flop, no logic after it.
  assign clk_out = cnt[N-1];
  assign count   = cnt;

`ifdef CLOCK_PRESCALER_TICK_EN
  // High for the cycle following an enabled wrap from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else begin
      tick <= en && (cnt == CNT_MAX);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_prescaler
// Brief   : Directed self-checking bench for clock_prescaler (N=4, N=1, N=16).
// Revision: 1.0  initial release
// ============================================================================
module tb_clock_prescaler;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        rst1_n = 1'b0;
  logic        rst16_n = 1'b0;

  logic        clk_out4;
  logic [3:0]  count4;
  logic        clk_out1;
  logic [0:0]  count1;
  logic        clk_out16;
  logic [15:0] count16;
`ifdef CLOCK_PRESCALER_TICK_EN
  logic        tick4;
  logic        tick1;
  logic        tick16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_prescaler #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clk_out(clk_out4), .count(count4)
`ifdef CLOCK_PRESCALER_TICK_EN
    , .tick(tick4)
`endif
  );

  clock_prescaler #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(1'b1), .clk_out(clk_out1), .count(count1)
`ifdef CLOCK_PRESCALER_TICK_EN
    , .tick(tick1)
`endif
  );

  clock_prescaler #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .en(1'b1), .clk_out(clk_out16), .count(count16)
`ifdef CLOCK_PRESCALER_TICK_EN
    , .tick(tick16)
`endif
  );

  always #5 clk = clk_run ? ~clk : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; rst1_n = 1'b0; en = 1'b1;
    repeat (3) step();
    check("rst_count", 32'(count4), 32'd0);
    check("rst_clkout", 32'(clk_out4), 32'd0);
`ifdef CLOCK_PRESCALER_TICK_EN
    check("rst_tick", 32'(tick4), 32'd0);
`endif

    // Full period after release, N=4 and N=1 side by side
    rst_n = 1'b1; rst1_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("seq_count", 32'(count4), 32'(i % 16));
      check("seq_clkout", 32'(clk_out4), (i % 16) >= 8 ? 32'd1 : 32'd0);
      check("n1_clkout", 32'(clk_out1), 32'(i % 2));
    end

    // Run 40 cycles then asynchronous mid-period reset
    repeat (40) step();
    check("run40_count", 32'(count4), 32'd8);
    check("run40_clkout", 32'(clk_out4), 32'd1);
    rst_n = 1'b0;
    #2;
    check("async_count", 32'(count4), 32'd0);
    check("async_clkout", 32'(clk_out4), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("resume_count", 32'(count4), 32'd1);

    // Hold at count 5 for 7 cycles
    repeat (4) step();
    check("pre_hold", 32'(count4), 32'd5);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("hold_count", 32'(count4), 32'd5);
      check("hold_clkout", 32'(clk_out4), 32'd0);
    end
    en = 1'b1;
    step();
    check("unhold_count", 32'(count4), 32'd6);
    step();
    check("late_low", 32'(clk_out4), 32'd0);
    step();
    check("late_high", 32'(clk_out4), 32'd1);

`ifdef CLOCK_PRESCALER_TICK_EN
    begin
      int pulses;
      int width;
      pulses = 0;
      width  = 0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
        step();
        if (tick4) begin
          pulses++;
          width++;
          check("tick_at_zero", 32'(count4), 32'd0);
        end else begin
          if (width != 0) check("tick_width", 32'(width), 32'd1);
          width = 0;
        end
      end
      check("tick_pulses", 32'(pulses), 32'd4);
    end
`endif

    // Asynchronous reset with the clock stopped
    step();
    step();
    clk_run = 1'b0;
    #20;
    check("stop_precond", 32'(count4 != 4'd0), 32'd1);
    rst_n = 1'b0;
    #3;
    check("stopped_count", 32'(count4), 32'd0);
    check("stopped_clkout", 32'(clk_out4), 32'd0);
    rst_n = 1'b1;
    clk_run = 1'b1;

    // N=16: rise at enabled cycle 32768, fall at 65536
    step();
    rst16_n = 1'b1;
    repeat (32767) step();
    check("n16_pre_rise", 32'(clk_out16), 32'd0);
    check("n16_pre_cnt", 32'(count16), 32'd32767);
    step();
    check("n16_rise", 32'(clk_out16), 32'd1);
    repeat (32767) step();
    check("n16_pre_fall", 32'(clk_out16), 32'd1);
    step();
    check("n16_fall", 32'(clk_out16), 32'd0);
    check("n16_wrap_cnt", 32'(count16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
